// File: rtl/solver_scheduler_if.sv
// Request/response/operand bundle between the two requesters, the scheduler
// and the shared Solver.
//   slave  : scheduler side (accepts requests, drives operands and responses)
//   master : requester/Solver side
// Parameters: RAW_W plaintext width, ENC_W ciphertext width, CNT_W job counter width.
interface solver_scheduler_if #(
  parameter int unsigned RAW_W = 60,
  parameter int unsigned ENC_W = 78,
  parameter int unsigned CNT_W = 16
);
  logic             enc_req_valid;
  logic             enc_req_ready;
  logic [RAW_W-1:0] enc_req_data;
  logic             dec_req_valid;
  logic             dec_req_ready;
  logic [ENC_W-1:0] dec_req_data;
  logic [RAW_W-1:0] sol_data_raw;
  logic [ENC_W-1:0] sol_data_enc;
  logic [ENC_W-1:0] sol_out_enc;
  logic [RAW_W-1:0] sol_out_raw;
  logic             enc_rsp_valid;
  logic             enc_rsp_ready;
  logic [ENC_W-1:0] enc_rsp_data;
  logic             dec_rsp_valid;
  logic             dec_rsp_ready;
  logic [RAW_W-1:0] dec_rsp_data;
  logic             busy;
  logic [CNT_W-1:0] done_cnt;

  modport slave (
    input  enc_req_valid, enc_req_data, dec_req_valid, dec_req_data,
    input  sol_out_enc, sol_out_raw, enc_rsp_ready, dec_rsp_ready,
    output enc_req_ready, dec_req_ready, sol_data_raw, sol_data_enc,
    output enc_rsp_valid, enc_rsp_data, dec_rsp_valid, dec_rsp_data,
    output busy, done_cnt
  );

  modport master (
    output enc_req_valid, enc_req_data, dec_req_valid, dec_req_data,
    output sol_out_enc, sol_out_raw, enc_rsp_ready, dec_rsp_ready,
    input  enc_req_ready, dec_req_ready, sol_data_raw, sol_data_enc,
    input  enc_rsp_valid, enc_rsp_data, dec_rsp_valid, dec_rsp_data,
    input  busy, done_cnt
  );
endinterface

// File: rtl/solver_scheduler.sv
// solver_scheduler: shares one Solver between an encrypt and a decrypt requester.
// Arbitrates in IDLE, loads the Solver operand register, waits SOLVER_LAT cycles
// for the Solver outputs to settle, captures the result and holds it on the
// matching response channel until it is consumed. One job in flight.
// Ports:
//   Clk  rising-edge clock
//   Rst  asynchronous active-high reset
//   bus  solver_scheduler_if.slave: enc/dec request and response handshakes,
//        Solver operand outputs and result inputs, busy, done_cnt
// Configuration macro: SCHED_ROUND_ROBIN_EN -- when defined, simultaneous
//   requests alternate against the last granted channel; otherwise encrypt
//   always wins ties.
module solver_scheduler #(
  parameter int unsigned RAW_W      = 60,
  parameter int unsigned ENC_W      = 78,
  parameter int unsigned SOLVER_LAT = 4,
  parameter int unsigned CNT_W      = 16
) (
  input logic               Clk,
  input logic               Rst,
  solver_scheduler_if.slave bus
);
  localparam int unsigned LAT_W = (SOLVER_LAT > 1) ? $clog2(SOLVER_LAT) : 1;
  localparam logic OP_ENC = 1'b0;
  localparam logic OP_DEC = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } stateT;

  stateT            state, stateNext;
  logic [LAT_W-1:0] cnt, cntNext;
  logic             curOp, curOpNext;
  logic             lastGrant, lastGrantNext;
  logic [RAW_W-1:0] solRaw, solRawNext;
  logic [ENC_W-1:0] solEnc, solEncNext;
  logic [ENC_W-1:0] encRspData, encRspDataNext;
  logic [RAW_W-1:0] decRspData, decRspDataNext;
  logic [CNT_W-1:0] doneCnt, doneCntNext;
  logic             encRspValid, encRspValidNext;
  logic             decRspValid, decRspValidNext;
  logic             busyQ, busyNext;
  logic             encReqReady, decReqReady;
  logic             grantEnc, grantDec, rspFire;

  // Arbitration winner among the currently valid requesters
`ifdef SCHED_ROUND_ROBIN_EN
  assign grantEnc = bus.enc_req_valid && (!bus.dec_req_valid || (lastGrant == OP_DEC));
`else
  assign grantEnc = bus.enc_req_valid;
`endif
  assign grantDec = bus.dec_req_valid && !grantEnc;

  assign rspFire = (curOp == OP_ENC) ? (encRspValid && bus.enc_rsp_ready)
                                     : (decRspValid && bus.dec_rsp_ready);

  // State and datapath registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      curOp       <= OP_ENC;
      lastGrant   <= OP_DEC;
      solRaw      <= '0;
      solEnc      <= '0;
      encRspData  <= '0;
      decRspData  <= '0;
      doneCnt     <= '0;
      encRspValid <= 1'b0;
      decRspValid <= 1'b0;
      busyQ       <= 1'b0;
    end else begin
      state       <= stateNext;
      cnt         <= cntNext;
      curOp       <= curOpNext;
      lastGrant   <= lastGrantNext;
      solRaw      <= solRawNext;
      solEnc      <= solEncNext;
      encRspData  <= encRspDataNext;
      decRspData  <= decRspDataNext;
      doneCnt     <= doneCntNext;
      encRspValid <= encRspValidNext;
      decRspValid <= decRspValidNext;
      busyQ       <= busyNext;
    end
  end

  // Next-state, next-data and request-ready logic
  always_comb begin
    stateNext      = state;
    cntNext        = cnt;
    curOpNext      = curOp;
    lastGrantNext  = lastGrant;
    solRawNext     = solRaw;
    solEncNext     = solEnc;
    encRspDataNext = encRspData;
    decRspDataNext = decRspData;
    doneCntNext    = doneCnt;
    encReqReady    = 1'b0;
    decReqReady    = 1'b0;

    case (state)
      S_IDLE: begin
        encReqReady = grantEnc;
        decReqReady = grantDec;
        if (grantEnc) begin
          solRawNext = bus.enc_req_data;
          curOpNext  = OP_ENC;
          cntNext    = LAT_W'(SOLVER_LAT - 1);
          stateNext  = S_WAIT;
        end else if (grantDec) begin
          solEncNext = bus.dec_req_data;
          curOpNext  = OP_DEC;
          cntNext    = LAT_W'(SOLVER_LAT - 1);
          stateNext  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          if (curOp == OP_ENC) encRspDataNext = bus.sol_out_enc;
          else                 decRspDataNext = bus.sol_out_raw;
          stateNext = S_RESP;
        end else begin
          cntNext = cnt - LAT_W'(1);
        end
      end
      S_RESP: begin
        if (rspFire) begin
          doneCntNext   = doneCnt + CNT_W'(1);
          lastGrantNext = curOp;
          stateNext     = S_IDLE;
        end
      end
      default: stateNext = S_IDLE;
    endcase
  end

  // Status flags registered from the next state so they line up with it
  assign busyNext        = (stateNext != S_IDLE);
  assign encRspValidNext = (stateNext == S_RESP) && (curOpNext == OP_ENC);
  assign decRspValidNext = (stateNext == S_RESP) && (curOpNext == OP_DEC);

  assign bus.enc_req_ready = encReqReady;
  assign bus.dec_req_ready = decReqReady;
  assign bus.sol_data_raw  = solRaw;
  assign bus.sol_data_enc  = solEnc;
  assign bus.enc_rsp_valid = encRspValid;
  assign bus.enc_rsp_data  = encRspData;
  assign bus.dec_rsp_valid = decRspValid;
  assign bus.dec_rsp_data  = decRspData;
  assign bus.busy          = busyQ;
  assign bus.done_cnt      = doneCnt;
endmodule

// File: tb/tb_solver_scheduler.sv
// Directed bench for solver_scheduler: table-driven single jobs plus
// hand-written sequences for contention, reset mid-job, counter wrap and
// an encrypt/decrypt round trip. The Solver is modelled as an invertible
// transform whose outputs read as garbage until SOLVER_LAT-1 negedges after
// an operand change.
module tb_solver_scheduler;
  localparam int unsigned RAW_W = 60;
  localparam int unsigned ENC_W = 78;
  localparam int unsigned LAT   = 4;
  localparam int unsigned CNT_W = 16;
  localparam logic [59:0] KEY = 60'hA5C31F0E9B27D46;
  localparam logic [17:0] TAG = 18'h2B3C9;
`ifdef SCHED_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  solver_scheduler_if #(.RAW_W(RAW_W), .ENC_W(ENC_W), .CNT_W(CNT_W)) bus ();
  solver_scheduler_if #(.RAW_W(RAW_W), .ENC_W(ENC_W), .CNT_W(4)) bus2 ();

  solver_scheduler #(.RAW_W(RAW_W), .ENC_W(ENC_W), .SOLVER_LAT(LAT), .CNT_W(CNT_W))
    u_dut (.Clk(Clk), .Rst(Rst), .bus(bus.slave));
  solver_scheduler #(.RAW_W(RAW_W), .ENC_W(ENC_W), .SOLVER_LAT(LAT), .CNT_W(4))
    u_dutWrap (.Clk(Clk), .Rst(Rst), .bus(bus2.slave));

  function automatic logic [77:0] encF(input logic [59:0] p);
    return {TAG, p ^ KEY};
  endfunction
  function automatic logic [59:0] decF(input logic [77:0] e);
    logic [59:0] lo;
    lo = e[59:0];
    return lo ^ KEY;
  endfunction

  // Solver model with settle time
  logic [59:0] prevRaw = '0;
  logic [77:0] prevEnc = '0;
  int rawAge = 255;
  int encAge = 255;
  always @(negedge Clk) begin
    if (bus.sol_data_raw != prevRaw) rawAge <= 0;
    else if (rawAge < 255) rawAge <= rawAge + 1;
    if (bus.sol_data_enc != prevEnc) encAge <= 0;
    else if (encAge < 255) encAge <= encAge + 1;
    prevRaw <= bus.sol_data_raw;
    prevEnc <= bus.sol_data_enc;
  end
  assign bus.sol_out_enc  = (rawAge >= int'(LAT) - 1) ? encF(prevRaw) : ~encF(prevRaw);
  assign bus.sol_out_raw  = (encAge >= int'(LAT) - 1) ? decF(prevEnc) : ~decF(prevEnc);
  assign bus2.sol_out_enc = encF(bus2.sol_data_raw);
  assign bus2.sol_out_raw = decF(bus2.sol_data_enc);

  int nChecks = 0;
  int nPass = 0;
  int expDone = 0;
  logic [59:0] expRawOp = '0;
  logic [77:0] expEncOp = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else nPass++;
  endtask

  task automatic doReset();
    @(negedge Clk);
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    expDone = 0;
    expRawOp = '0;
    expEncOp = '0;
  endtask

  // One isolated job; hold = cycles the response is left unconsumed
  task automatic runJob(input bit isDec, input logic [77:0] din, input logic [77:0] expv,
                        input int hold, input string tag, output logic [77:0] got);
    logic [59:0] dinRaw;
    dinRaw = din[59:0];
    @(negedge Clk);
    if (isDec) begin bus.dec_req_valid = 1'b1; bus.dec_req_data = din; end
    else       begin bus.enc_req_valid = 1'b1; bus.enc_req_data = dinRaw; end
    #1;
    check({tag, ".reqReady"}, isDec ? bus.dec_req_ready : bus.enc_req_ready, 1);
    @(posedge Clk); #1;
    bus.enc_req_valid = 1'b0;
    bus.dec_req_valid = 1'b0;
    if (isDec) expEncOp = din; else expRawOp = dinRaw;
    check({tag, ".opRaw"}, bus.sol_data_raw, expRawOp);
    check({tag, ".opEnc"}, bus.sol_data_enc, expEncOp);
    check({tag, ".busy"}, bus.busy, 1);
    for (int k = 1; k < int'(LAT); k++) begin
      @(posedge Clk); #1;
      check($sformatf("%s.earlyValid%0d", tag, k), {bus.enc_rsp_valid, bus.dec_rsp_valid}, 2'b00);
    end
    @(posedge Clk); #1;
    check({tag, ".rspValid"}, {bus.enc_rsp_valid, bus.dec_rsp_valid}, isDec ? 2'b01 : 2'b10);
    got = isDec ? 78'(bus.dec_rsp_data) : bus.enc_rsp_data;
    check({tag, ".rspData"}, got, expv);
    if (hold > 0) begin
      if (isDec) bus.enc_req_valid = 1'b1; else bus.dec_req_valid = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(posedge Clk); #1;
        check($sformatf("%s.holdValid%0d", tag, h),
              isDec ? bus.dec_rsp_valid : bus.enc_rsp_valid, 1);
        check($sformatf("%s.holdData%0d", tag, h),
              isDec ? 78'(bus.dec_rsp_data) : bus.enc_rsp_data, expv);
        check($sformatf("%s.holdBlock%0d", tag, h),
              {bus.enc_req_ready, bus.dec_req_ready, bus.busy}, 3'b001);
      end
      bus.enc_req_valid = 1'b0;
      bus.dec_req_valid = 1'b0;
    end
    if (isDec) bus.dec_rsp_ready = 1'b1; else bus.enc_rsp_ready = 1'b1;
    @(posedge Clk); #1;
    bus.enc_rsp_ready = 1'b0;
    bus.dec_rsp_ready = 1'b0;
    expDone++;
    check({tag, ".doneCnt"}, bus.done_cnt, 16'(expDone));
    check({tag, ".idle"}, {bus.busy, bus.enc_rsp_valid, bus.dec_rsp_valid}, 3'b000);
  endtask

  typedef struct {
    bit          isDec;
    logic [77:0] din;
    logic [77:0] expv;
    int          hold;
  } vecT;
  vecT vecs[5];

  initial begin
    logic [77:0] got, encP;
    int cyc;
    Rst = 1'b1;
    bus.enc_req_valid = 0; bus.enc_req_data = '0; bus.dec_req_valid = 0; bus.dec_req_data = '0;
    bus.enc_rsp_ready = 0; bus.dec_rsp_ready = 0;
    bus2.enc_req_valid = 0; bus2.enc_req_data = '0; bus2.dec_req_valid = 0; bus2.dec_req_data = '0;
    bus2.enc_rsp_ready = 0; bus2.dec_rsp_ready = 0;

    vecs[0] = '{1'b0, 78'(60'h123456789ABCDEF), encF(60'h123456789ABCDEF), 0};
    vecs[1] = '{1'b1, 78'h3_0000_0000_0000_0000_5, 78'(decF(78'h3_0000_0000_0000_0000_5)), 10};
    vecs[2] = '{1'b0, 78'(60'h0), encF(60'h0), 2};
    vecs[3] = '{1'b0, 78'(60'hFFFFFFFFFFFFFFF), encF(60'hFFFFFFFFFFFFFFF), 0};
    vecs[4] = '{1'b1, encF(60'hFEDCBA987654321), 78'(60'hFEDCBA987654321), 1};

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    check("reset.flags", {bus.busy, bus.enc_rsp_valid, bus.dec_rsp_valid,
                          bus.enc_req_ready, bus.dec_req_ready}, 5'b0);
    check("reset.doneCnt", bus.done_cnt, 0);
    check("reset.ops", {bus.sol_data_raw, bus.sol_data_enc}, 0);

    for (int i = 0; i < 5; i++)
      runJob(vecs[i].isDec, vecs[i].din, vecs[i].expv, vecs[i].hold, $sformatf("vec%0d", i), got);

    // Round trip: encrypt then decrypt the result
    runJob(1'b0, 78'(60'h0F1E2D3C4B5A697), encF(60'h0F1E2D3C4B5A697), 0, "rtEnc", encP);
    runJob(1'b1, encP, 78'(60'h0F1E2D3C4B5A697), 0, "rtDec", got);

    // Contention: both requesters valid every cycle
    doReset();
    @(negedge Clk);
    bus.enc_req_valid = 1'b1; bus.enc_req_data = 60'h111;
    bus.dec_req_valid = 1'b1; bus.dec_req_data = 78'h222;
    bus.enc_rsp_ready = 1'b1; bus.dec_rsp_ready = 1'b1;
    #1;
    for (int j = 0; j < 6; j++) begin
      cyc = 0;
      while (!(bus.enc_req_ready || bus.dec_req_ready) && cyc < 30) begin
        @(negedge Clk); #1;
        cyc++;
      end
      check($sformatf("arb.period%0d", j), 32'(cyc), (j == 0) ? 0 : LAT + 1);
      check($sformatf("arb.grant%0d", j), {bus.enc_req_ready, bus.dec_req_ready},
            (RR && (j % 2 == 1)) ? 2'b01 : 2'b10);
      @(posedge Clk);
      @(negedge Clk); #1;
    end
    bus.enc_req_valid = 1'b0;
    bus.dec_req_valid = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 30) begin @(negedge Clk); #1; cyc++; end
    check("arb.drained", bus.busy, 0);
    check("arb.doneCnt", bus.done_cnt, 6);
    bus.enc_rsp_ready = 1'b0; bus.dec_rsp_ready = 1'b0;

    // Reset two cycles into a job discards it
    doReset();
    @(negedge Clk);
    bus.enc_req_valid = 1'b1; bus.enc_req_data = 60'h55;
    @(posedge Clk); #1;
    bus.enc_req_valid = 1'b0;
    bus.enc_rsp_ready = 1'b1;
    repeat (2) @(posedge Clk);
    #1; Rst = 1'b1;
    #1;
    check("rstJob.busyAsync", bus.busy, 0);
    check("rstJob.opCleared", bus.sol_data_raw, 0);
    @(negedge Clk);
    Rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge Clk); #1;
      check($sformatf("rstJob.noRsp%0d", k), {bus.enc_rsp_valid, bus.busy}, 2'b00);
    end
    check("rstJob.doneCnt", bus.done_cnt, 0);
    @(negedge Clk);
    bus.enc_req_valid = 1'b1;
    #1;
    check("rstJob.readyAfter", bus.enc_req_ready, 1);
    bus.enc_req_valid = 1'b0;
    bus.enc_rsp_ready = 1'b0;

    // Counter wrap on the narrow-counter instance
    @(negedge Clk);
    bus2.enc_req_valid = 1'b1; bus2.enc_req_data = 60'h7; bus2.enc_rsp_ready = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      cyc = 0;
      do begin @(negedge Clk); cyc++; end while (!bus2.enc_rsp_valid && cyc < 20);
      check($sformatf("wrap.inTime%0d", j), 32'(cyc < 20), 1);
      @(posedge Clk); #1;
      if (j == 1)  check("wrap.first", bus2.done_cnt, 1);
      if (j == 15) check("wrap.max", bus2.done_cnt, 4'hF);
      if (j == 16) begin
        bus2.enc_req_valid = 1'b0;
        check("wrap.zero", bus2.done_cnt, 0);
      end
    end
    bus2.enc_rsp_ready = 1'b0;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
